// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store unit between execute and writeback with a handshaked data bus
// Four-state FSM: aligned memory ops go to the bus, misaligned and non-memory ops respond directly.
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        flush,
  output logic        in_ready,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  output logic [63:0] out_rdata,
  output logic        out_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic        r_unsigned;
  logic        r_kill;
  logic        r_misalign;
  logic [1:0]  r_size;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_aligned;
  logic        w_misaligned;
  logic        w_done;
  logic        w_kill_now;
  logic [7:0]  w_mask;
  logic [63:0] w_shift;
  logic [63:0] w_load;

  assign w_accept     = (r_state == S_IDLE) && in_valid && !flush;
  assign w_is_mem     = mem_read | mem_write;
  assign w_misaligned = w_is_mem & ~w_aligned;
  assign w_done       = ((r_state == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                        ((r_state == S_WAIT) && dresp_data_ok);
  // A flush arriving in the completing cycle must still suppress the result.
  assign w_kill_now   = r_kill | flush;

  always_comb begin
    w_aligned = 1'b1;
    case (mem_size)
      2'd0:    w_aligned = 1'b1;
      2'd1:    w_aligned = ~addr[0];
      2'd2:    w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = (addr[2:0] == 3'b000);
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (w_is_mem && !w_misaligned) ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (dresp_addr_ok) begin
          w_next = dresp_data_ok ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (dresp_data_ok) begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_shift = dresp_data >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_load = 64'd0;
    w_mask = 8'h00;
    case (r_size)
      2'd0: begin
        w_load = {{56{w_shift[7]  & ~r_unsigned}}, w_shift[7:0]};
        w_mask = 8'h01;
      end
      2'd1: begin
        w_load = {{48{w_shift[15] & ~r_unsigned}}, w_shift[15:0]};
        w_mask = 8'h03;
      end
      2'd2: begin
        w_load = {{32{w_shift[31] & ~r_unsigned}}, w_shift[31:0]};
        w_mask = 8'h0F;
      end
      default: begin
        w_load = w_shift;
        w_mask = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_kill     <= 1'b0;
      r_misalign <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= 64'd0;
      r_wdata    <= 64'd0;
      r_rdata    <= 64'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write    <= mem_write;
        r_size     <= mem_size;
        r_unsigned <= mem_unsigned;
        r_addr     <= addr;
        r_wdata    <= wdata;
        if (!w_is_mem || w_misaligned) begin
          r_rdata    <= 64'd0;
          r_misalign <= w_misaligned;
        end
      end
      if (r_state == S_RESP) begin
        r_kill <= 1'b0;
      end else if (r_state != S_IDLE && flush) begin
        r_kill <= 1'b1;
      end
      if (w_done && !w_kill_now) begin
        r_rdata    <= r_write ? 64'd0 : w_load;
        r_misalign <= 1'b0;
      end
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign dreq_valid   = (r_state == S_REQ);
  assign dreq_addr    = r_addr;
  assign dreq_size    = r_size;
  assign dreq_strobe  = r_write ? (w_mask << r_addr[2:0]) : 8'h00;
  assign dreq_data    = r_wdata << {r_addr[2:0], 3'b000};
  assign out_valid    = (r_state == S_RESP) && !r_kill;
  assign out_rdata    = r_rdata;
  assign out_misalign = r_misalign;

endmodule
